// File: rtl/risc_dbg_pkg.sv
// Shared definitions for the MIPS debug/program-loader engine.
//   - Host command opcodes carried on cmd_op.
//   - Engine FSM state encoding.
//   - HLT instruction opcode, used when building test programs.
package risc_dbg_pkg;

    localparam logic [1:0] OP_WRMEM = 2'b00;
    localparam logic [1:0] OP_RDREG = 2'b01;
    localparam logic [1:0] OP_RUN   = 2'b10;
    localparam logic [1:0] OP_DUMP  = 2'b11;

    // Primary opcode field [31:26] of the core's halt instruction.
    localparam logic [5:0] OP_HLT   = 6'h3f;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRMEM,
        ST_RDREG,
        ST_RUN,
        ST_WAIT_HALT,
        ST_DUMP,
        ST_RESP
    } dbg_state_e;

endpackage

// File: rtl/risc_dbg_rsp_reg.sv
// Single-entry response holding register for the debug loader.
// Once loaded, the beat stays valid with stable data/last/err until the
// host takes it (o_valid & i_ready). The engine only loads while empty.
// Ports:
//   clk_in, reset   clock, synchronous active-high reset
//   i_load          capture i_data/i_last/i_err and raise o_valid
//   i_data/i_last/i_err  beat contents
//   i_ready         host accepts the current beat
//   o_valid/o_data/o_last/o_err  held beat
//   o_accept        beat handshake this cycle
module risc_dbg_rsp_reg (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        i_load,
    input  logic [31:0] i_data,
    input  logic        i_last,
    input  logic        i_err,
    input  logic        i_ready,
    output logic        o_valid,
    output logic [31:0] o_data,
    output logic        o_last,
    output logic        o_err,
    output logic        o_accept
);

    logic        r_valid;
    logic [31:0] r_data;
    logic        r_last;
    logic        r_err;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
            r_err   <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_last  <= i_last;
            r_err   <= i_err;
        end else if (r_valid && i_ready) begin
            // Data is left in place; only the flags drop with the beat.
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_err   <= 1'b0;
        end
    end

    assign o_valid  = r_valid;
    assign o_data   = r_data;
    assign o_last   = r_last;
    assign o_err    = r_err;
    assign o_accept = r_valid & i_ready;

endmodule

// File: rtl/risc_dbg_loader.sv
// Debug/program-loader engine for the 5-stage MIPS core.
// Accepts one host command at a time and answers on the response channel:
//   WRITE_MEM  one instruction-memory write (core forced back into hold)
//   READ_REG   one register-file read
//   RUN        release the core and report cycles until HALTED
//   DUMP       stream REG[lo..hi], one beat per response handshake
// Optional build macro DBG_TIMEOUT_EN: RUN gives up after TIMEOUT_CYC
// cycles, answering with rsp_err=1 and re-holding the core.
// Ports:
//   clk_in, reset                      clock, synchronous active-high reset
//   cmd_valid/cmd_ready/cmd_op/cmd_addr/cmd_data   host command channel
//   rsp_valid/rsp_ready/rsp_data/rsp_last/rsp_err  host response channel
//   mem_we/mem_addr/mem_wdata          instruction-memory write port
//   reg_raddr/reg_rdata                register-file read port (comb data)
//   cpu_hold/cpu_halted                core hold-reset and HALTED flag
module risc_dbg_loader
    import risc_dbg_pkg::*;
#(
    parameter int MEM_AW      = 10,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [MEM_AW-1:0] cmd_addr,
    input  logic [31:0]       cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_data,
    output logic              rsp_last,
    output logic              rsp_err,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [4:0]        reg_raddr,
    input  logic [31:0]       reg_rdata,
    output logic              cpu_hold,
    input  logic              cpu_halted
);

    localparam logic [31:0] TO_LIM = 32'(TIMEOUT_CYC);

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    dbg_state_e        r_state;
    logic              r_cmd_ready;
    logic              r_mem_we;
    logic [MEM_AW-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic [4:0]        r_reg_raddr;
    logic              r_cpu_hold;
    logic [4:0]        r_idx;
    logic [4:0]        r_hi;
    logic [31:0]       r_cnt;

    logic              w_ld;
    logic [31:0]       w_ld_data;
    logic              w_ld_last;
    logic              w_ld_err;
    logic [31:0]       w_cnt_next;
    logic              w_to_hit;
    logic              w_timeout;
    logic              w_rsp_last;
    logic              w_rsp_accept;

    assign w_cnt_next = sat_inc(r_cnt);
    assign w_to_hit   = (w_cnt_next == TO_LIM);

`ifdef DBG_TIMEOUT_EN
    assign w_timeout = w_to_hit;
`else
    // Watchdog compiled out: RUN waits for HALTED indefinitely.
    assign w_timeout = w_to_hit & 1'b0;
`endif

    // Response beat produced by the current state; the FSM moves to RESP
    // on exactly the cycles this loads the holding register.
    always_comb begin
        w_ld      = 1'b0;
        w_ld_data = '0;
        w_ld_last = 1'b0;
        w_ld_err  = 1'b0;
        case (r_state)
            ST_WRMEM: begin
                w_ld      = 1'b1;
                w_ld_last = 1'b1;
            end
            ST_RDREG: begin
                w_ld      = 1'b1;
                w_ld_data = reg_rdata;
                w_ld_last = 1'b1;
            end
            ST_WAIT_HALT: begin
                if (cpu_halted) begin
                    w_ld      = 1'b1;
                    w_ld_data = w_cnt_next;
                    w_ld_last = 1'b1;
                end else if (w_timeout) begin
                    w_ld      = 1'b1;
                    w_ld_data = TO_LIM;
                    w_ld_last = 1'b1;
                    w_ld_err  = 1'b1;
                end
            end
            ST_DUMP: begin
                w_ld      = 1'b1;
                w_ld_data = reg_rdata;
                // Covers both the normal end and lo > hi (single beat).
                w_ld_last = (r_idx >= r_hi);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_reg_raddr <= '0;
            r_cpu_hold  <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_cmd_ready && cmd_valid) begin
                        r_cmd_ready <= 1'b0;
                        case (cmd_op)
                            OP_WRMEM: begin
                                r_mem_we    <= 1'b1;
                                r_mem_addr  <= cmd_addr;
                                r_mem_wdata <= cmd_data;
                                // Hold rises with the write so a running
                                // core never fetches a half-loaded program.
                                r_cpu_hold  <= 1'b1;
                                r_state     <= ST_WRMEM;
                            end
                            OP_RDREG: begin
                                r_reg_raddr <= cmd_addr[4:0];
                                r_state     <= ST_RDREG;
                            end
                            OP_RUN: begin
                                r_cpu_hold  <= 1'b0;
                                r_cnt       <= '0;
                                r_state     <= ST_RUN;
                            end
                            default: begin // OP_DUMP
                                r_reg_raddr <= cmd_addr[4:0];
                                r_idx       <= cmd_addr[4:0];
                                r_hi        <= cmd_data[4:0];
                                r_state     <= ST_DUMP;
                            end
                        endcase
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end
                ST_WRMEM: begin
                    r_mem_we <= 1'b0;
                    r_state  <= ST_RESP;
                end
                ST_RDREG: r_state <= ST_RESP;
                ST_RUN:   r_state <= ST_WAIT_HALT;
                ST_WAIT_HALT: begin
                    r_cnt <= w_cnt_next;
                    if (w_ld) begin
                        r_state <= ST_RESP;
                        if (w_ld_err) begin
                            r_cpu_hold <= 1'b1;
                        end
                    end
                end
                ST_DUMP: r_state <= ST_RESP;
                ST_RESP: begin
                    if (w_rsp_accept) begin
                        if (w_rsp_last) begin
                            r_state     <= ST_IDLE;
                            r_cmd_ready <= 1'b1;
                        end else begin
                            r_idx       <= r_idx + 5'd1;
                            r_reg_raddr <= r_idx + 5'd1;
                            r_state     <= ST_DUMP;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    risc_dbg_rsp_reg u_rsp (
        .clk_in   (clk_in),
        .reset    (reset),
        .i_load   (w_ld),
        .i_data   (w_ld_data),
        .i_last   (w_ld_last),
        .i_err    (w_ld_err),
        .i_ready  (rsp_ready),
        .o_valid  (rsp_valid),
        .o_data   (rsp_data),
        .o_last   (w_rsp_last),
        .o_err    (rsp_err),
        .o_accept (w_rsp_accept)
    );

    assign rsp_last  = w_rsp_last;
    assign cmd_ready = r_cmd_ready;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign reg_raddr = r_reg_raddr;
    assign cpu_hold  = r_cpu_hold;

endmodule
